// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage RV32I pipeline. It produces
//   the enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. It handles three cases:
//     - load-use hazards (one-cycle bubble),
//     - taken branches and jumps resolved in EX (flush of the wrong path),
//     - multi-cycle data-memory accesses in MEM (freeze, with a timeout).
//   It also keeps a saturating count of the cycles in which the PC is held.
//
// Handshake: DMEM_REQ follows MEM_REQ. An access completes in the first
//   cycle in which DMEM_REQ and DMEM_READY are both high. Until that cycle the
//   whole pipeline is frozen and a bubble is written into MEM/WB. If
//   TIMEOUT_CYCLES cycles pass in MEM_WAIT without DMEM_READY, the access is
//   abandoned and the sticky BUS_ERR flag is set.
//
// Ports
//   CLK, RESET          clock (rising edge) and asynchronous active-high reset
//   i_id_rs1/2, _used   source registers of the instruction in ID
//   i_ex_rd             destination register of the instruction in EX
//   i_ex_mem_read       the instruction in EX is a load
//   i_ex_branch_taken   EX resolved a taken branch, JAL or JALR
//   i_mem_req           the instruction in MEM accesses data memory
//   i_dmem_ready        data memory completes its access this cycle
//   o_*_en / o_*_flush  pipeline register controls
//   o_dmem_req          request strobe to data memory
//   o_bus_err           sticky memory-timeout flag
//   o_stall_count       saturating count of cycles with o_pc_en = 0
//   o_dbg_state         1 while the FSM is in MEM_WAIT
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_mem_wb_flush,
  output logic             o_dmem_req,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_stall_count,
  output logic             o_dbg_state
);

  typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_stall_count;

  logic w_load_use;
  logic w_mem_stall;
  logic w_freeze;
  logic w_timeout;

  assign w_load_use  = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                       ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                        (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));
  assign w_mem_stall = i_mem_req && !i_dmem_ready;

  // In MEM_WAIT only DMEM_READY and the wait counter matter. Reaching the
  // timeout releases the pipeline exactly as a late ready would.
  assign w_freeze  = (r_state == ST_RUN) ? w_mem_stall
                                         : (!i_dmem_ready && (r_wait_cnt != LP_TIMEOUT));
  assign w_timeout = (r_state == ST_MEM_WAIT) && !i_dmem_ready &&
                     (r_wait_cnt == LP_TIMEOUT);

  always_comb begin
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b1;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_en    = 1'b1;
    o_mem_wb_en    = 1'b1;
    o_mem_wb_flush = 1'b0;
    if (RESET) begin
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
    end else if (w_freeze) begin
      // A branch or load-use seen while frozen is not lost: its inputs stay
      // held by the frozen pipeline and are acted on in the release cycle.
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_en     = 1'b0;
      o_ex_mem_en    = 1'b0;
      o_mem_wb_en    = 1'b0;
      o_mem_wb_flush = 1'b1;
    end else if (i_ex_branch_taken) begin
      // The instruction in ID is on the wrong path, so any load-use it causes
      // is irrelevant.
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
  end

  assign o_dmem_req    = i_mem_req && !RESET;
  assign o_bus_err     = r_bus_err;
  assign o_stall_count = r_stall_count;
  assign o_dbg_state   = (r_state == ST_MEM_WAIT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_bus_err     <= 1'b0;
      r_stall_count <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (i_dmem_ready || w_timeout) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            if (w_timeout) r_bus_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= 8'd0;
        end
      endcase
      if (!o_pc_en && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Self-checking bench for pipeline_hazard_ctrl, with TIMEOUT_CYCLES = 4.
//   Inputs change 1 ns after each rising edge. For every cycle a reference
//   model computes the expected controls and pushes them into exp_q. A
//   separate monitor samples the DUT on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int T   = 4;
  localparam int CW  = 32;
  localparam int EW  = 10 + CW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          rs1_used = 0, rs2_used = 0, ex_mem_read = 0, ex_br = 0;
  logic          mem_req = 0, dmem_ready = 0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, mem_wb_en, mem_wb_flush, dmem_req, bus_err, dbg_state;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read),
    .i_ex_branch_taken(ex_br), .i_mem_req(mem_req), .i_dmem_ready(dmem_ready),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
    .o_id_ex_en(id_ex_en), .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
    .o_mem_wb_flush(mem_wb_flush), .o_dmem_req(dmem_req),
    .o_bus_err(bus_err), .o_stall_count(stall_count), .o_dbg_state(dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            n_vec  = 0;
  int            n_err  = 0;
  int            cyc    = 0;

  // Reference model state. It describes the access in progress by how many
  // cycles it has already stalled, rather than by FSM states.
  bit            m_waiting = 0;
  int            m_stalled = 0;
  bit            m_bus_err = 0;
  logic [CW-1:0] m_cnt     = '0;

  task automatic drv(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input bit u1, input bit u2, input bit mr,
                     input bit br, input bit mreq, input bit rdy);
    bit lu, hold, tmo, pc, ifen, iffl, idexen, idexfl, exmen, mwen, mwfl, req;
    @(posedge CLK);
    #1;
    RESET = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; rs1_used = u1;
    rs2_used = u2; ex_mem_read = mr; ex_br = br; mem_req = mreq; dmem_ready = rdy;
    cyc++;
    if (rst) begin
      m_waiting = 0; m_stalled = 0; m_bus_err = 0; m_cnt = '0;
      exp_q.push_back({10'b0, {CW{1'b0}}});
    end else begin
      lu   = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      // A new access stalls while the memory is not ready. One that is
      // already waiting is given up after T stalled cycles.
      hold = m_waiting ? (!rdy && m_stalled < T) : (mreq && !rdy);
      tmo  = m_waiting && !rdy && m_stalled >= T;
      {pc, ifen, iffl, idexen, idexfl, exmen, mwen, mwfl} = 8'b1101_0110;
      if (hold)          {pc, ifen, idexen, exmen, mwen, mwfl} = 6'b000001;
      else if (br)       {iffl, idexfl} = 2'b11;
      else if (lu)       {pc, ifen, idexfl} = 3'b001;
      req = mreq;
      exp_q.push_back({pc, ifen, iffl, idexen, idexfl, exmen, mwen, mwfl, req,
                       m_bus_err, m_cnt});
      if (hold) begin m_stalled = m_stalled + 1; m_waiting = 1; end
      else begin m_stalled = 0; m_waiting = 0; end
      if (tmo) m_bus_err = 1;
      if (!pc && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor
  always @(negedge CLK) begin
    logic [EW-1:0] got, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got   = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_en, mem_wb_flush, dmem_req, bus_err, stall_count};
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL ctrl cyc%0d got ctl=%b cnt=%0d exp ctl=%b cnt=%0d", cyc,
                 got[EW-1:CW], got[CW-1:0], exp_v[EW-1:CW], exp_v[CW-1:0]);
      end
    end
  end

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use: lw x5 in EX, add rs1=x5 in ID
    drv(0, 5, 1, 5, 1, 1, 1, 0, 0, 0);
    idle(1);
    // no stall: rd = x0, then an rs2 match with rs2 unused
    drv(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    drv(0, 3, 5, 5, 1, 0, 1, 0, 0, 0);
    // branch together with load-use
    drv(0, 5, 0, 5, 1, 0, 1, 1, 0, 0);
    // zero-wait access
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // ready low for 3 cycles, then ready
    repeat (3) drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // load-use held during a wait, acted on when the access completes
    repeat (2) drv(0, 7, 0, 7, 1, 0, 1, 0, 1, 0);
    drv(0, 7, 0, 7, 1, 0, 1, 0, 1, 1);
    idle(1);
    // timeout: ready never comes
    repeat (5) drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // reset pulsed during MEM_WAIT
    repeat (2) drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drv(($urandom_range(0, 99) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
